// File: rtl/ice_ram_pkg.sv
// ice_ram_pkg: shared constants and types for the ice_ram32 block RAM.
//   ICE_RAM_ADDR_W - default address width (depth = 2**ICE_RAM_ADDR_W words)
//   ICE_RAM_DATA_W - default word width for data, mask and read data
//   ice_ram_addr_t - address type
//   ice_ram_word_t - data word type
package ice_ram_pkg;
  localparam int ICE_RAM_ADDR_W = 8;
  localparam int ICE_RAM_DATA_W = 32;

  typedef logic [ICE_RAM_ADDR_W-1:0] ice_ram_addr_t;
  typedef logic [ICE_RAM_DATA_W-1:0] ice_ram_word_t;
endpackage

// File: rtl/ice_ram32_array.sv
// ice_ram32_array: storage array with per-bit masked write port.
// Ports:
//   gclk   - clock, array updates on rising edge
//   WDATA  - write data
//   MASK   - per-bit write mask, 1 = keep old bit
//   WADDR  - write address
//   WE     - write enable
//   WCLKE  - write clock enable (both WE and WCLKE must be high to write)
//   RADDR  - read address
//   rdWord - combinational contents of r_data[RADDR] (pre-write value)
// The array is never reset: contents survive reset and writes proceed
// while reset is held, so the register file can clear R0 during reset.
import ice_ram_pkg::*;

module ice_ram32_array #(
  parameter int ADDR_W = ICE_RAM_ADDR_W,
  parameter int DATA_W = ICE_RAM_DATA_W
) (
  input  logic              gclk,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] MASK,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic              WE,
  input  logic              WCLKE,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [DATA_W-1:0] rdWord
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_data [0:DEPTH-1];

  // Masked bits take their old value, so a full-ones mask is a no-op write.
  always_ff @(posedge gclk) begin
    if (WE && WCLKE) begin
      r_data[WADDR] <= (WDATA & ~MASK) | (r_data[WADDR] & MASK);
    end
  end

  assign rdWord = r_data[RADDR];
endmodule

// File: rtl/ice_ram32.sv
// ice_ram32: 256 x 32 simple-dual-port RAM, iCE40 block-RAM style interface.
// Ports:
//   gclk   - clock, storage and read register update on rising edge
//   grst   - asynchronous active-low reset, clears RDATA only
//   RDATA  - registered read data (1-cycle latency)
//   RADDR  - read address
//   RE     - read enable
//   RCLKE  - read clock enable
//   WDATA  - write data
//   MASK   - per-bit write mask, 1 = bit not written
//   WADDR  - write address
//   WE     - write enable
//   WCLKE  - write clock enable
// Enable semantics: a read is captured on a rising edge when RE, RCLKE and
// grst are all high, otherwise RDATA holds; a write happens on a rising edge
// when WE and WCLKE are both high, independent of grst.
// Build option ICE_RAM32_BYPASS_EN: same-address read/write in one edge
// returns the merged new word (write-first); without it the read returns the
// pre-write word (read-first).
import ice_ram_pkg::*;

module ice_ram32 #(
  parameter int ADDR_W = ICE_RAM_ADDR_W,
  parameter int DATA_W = ICE_RAM_DATA_W
) (
  input  logic              gclk,
  input  logic              grst,
  output logic [DATA_W-1:0] RDATA,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic              RE,
  input  logic              RCLKE,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] MASK,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic              WE,
  input  logic              WCLKE
);
  logic [DATA_W-1:0] rdWord;
  logic [DATA_W-1:0] rdNext;
  logic              rdEn;

  ice_ram32_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) ram (
    .gclk  (gclk),
    .WDATA (WDATA),
    .MASK  (MASK),
    .WADDR (WADDR),
    .WE    (WE),
    .WCLKE (WCLKE),
    .RADDR (RADDR),
    .rdWord(rdWord)
  );

  assign rdEn = RE && RCLKE;

`ifdef ICE_RAM32_BYPASS_EN
  logic collide;
  assign collide = WE && WCLKE && (RADDR == WADDR);
  // On collision, forward the word the array is about to hold.
  assign rdNext  = collide ? ((WDATA & ~MASK) | (rdWord & MASK)) : rdWord;
`else
  // Read-first: the array still holds the pre-write word at this edge.
  assign rdNext  = rdWord;
`endif

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      RDATA <= '0;
    end else if (rdEn) begin
      RDATA <= rdNext;
    end
  end
endmodule

// File: tb/tb_ice_ram32.sv
// tb_ice_ram32: self-checking bench for ice_ram32 with a word-array model.
// Inputs are driven 1 time unit after the rising edge; RDATA is checked
// 1 time unit after the following rising edge.
module tb_ice_ram32;
  logic        gclk;
  logic        grst;
  logic [31:0] RDATA;
  logic [7:0]  RADDR;
  logic        RE;
  logic        RCLKE;
  logic [31:0] WDATA;
  logic [31:0] MASK;
  logic [7:0]  WADDR;
  logic        WE;
  logic        WCLKE;

  int checkCnt = 0;
  int passCnt  = 0;

  logic [31:0] model [0:255];
  logic [31:0] expRd;
  logic [31:0] exp_q [$];

  ice_ram32 dut (
    .gclk (gclk),
    .grst (grst),
    .RDATA(RDATA),
    .RADDR(RADDR),
    .RE   (RE),
    .RCLKE(RCLKE),
    .WDATA(WDATA),
    .MASK (MASK),
    .WADDR(WADDR),
    .WE   (WE),
    .WCLKE(WCLKE)
  );

  // ---------------- clock / reset ----------------
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // ---------------- driver tasks ----------------
  task automatic preload(input int addr, input logic [31:0] val);
    dut.ram.r_data[addr] = val;
    model[addr] = val;
  endtask

  task automatic idleInputs();
    RE = 1'b0; RCLKE = 1'b0; RADDR = '0;
    WE = 1'b0; WCLKE = 1'b0; WADDR = '0; WDATA = '0; MASK = '0;
  endtask

  // Evaluate the model from the inputs present before the edge, then advance.
  task automatic stepCycle();
    logic [31:0] oldWord;
    oldWord = model[RADDR];
    if (!grst) begin
      expRd = 32'h0;
    end else if (RE && RCLKE) begin
      expRd = oldWord;
`ifdef ICE_RAM32_BYPASS_EN
      if (WE && WCLKE && (RADDR == WADDR)) begin
        for (int b = 0; b < 32; b++) if (!MASK[b]) expRd[b] = WDATA[b];
      end
`endif
    end
    if (WE && WCLKE) begin
      for (int b = 0; b < 32; b++) if (!MASK[b]) model[WADDR][b] = WDATA[b];
    end
    @(posedge gclk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idleInputs();
    grst = 1'b0;
    RE = 1'b1; RCLKE = 1'b1; RADDR = 8'd5;
    WE = 1'b1; WCLKE = 1'b1; WADDR = 8'd0; WDATA = 32'h0; MASK = 32'h0;
    preload(5, 32'hCAFE0005);
    preload(0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkCnt++;
      if (RDATA !== 32'h0) $display("FAIL reset_hold cyc %0d: got %h want %h", i, RDATA, 32'h0);
      else passCnt++;
    end
    WE = 1'b0;
    grst = 1'b1;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'hCAFE0005) $display("FAIL reset_first_read: got %h want %h", RDATA, 32'hCAFE0005);
    else passCnt++;
    RADDR = 8'd0;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h0) $display("FAIL write_during_reset: got %h want %h", RDATA, 32'h0);
    else passCnt++;
    RADDR = 8'd5;
    stepCycle();
    // Assert reset between edges: RDATA must clear without a clock edge.
    grst = 1'b0;
    #1;
    checkCnt++;
    if (RDATA !== 32'h0) $display("FAIL async_reset: got %h want %h", RDATA, 32'h0);
    else passCnt++;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h0) $display("FAIL async_reset_hold: got %h want %h", RDATA, 32'h0);
    else passCnt++;
    grst = 1'b1;
  endtask

  task automatic test_masked_write();
    idleInputs();
    preload(3, 32'h12345678);
    WE = 1'b1; WCLKE = 1'b1; WADDR = 8'd3; WDATA = 32'hFFFFFFFF; MASK = 32'hFFFF0000;
    stepCycle();
    WE = 1'b0; RE = 1'b1; RCLKE = 1'b1; RADDR = 8'd3;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h1234FFFF) $display("FAIL masked_write: got %h want %h", RDATA, 32'h1234FFFF);
    else passCnt++;
    // All-ones mask writes nothing.
    RE = 1'b0; WE = 1'b1; WCLKE = 1'b1; WDATA = 32'h0; MASK = 32'hFFFFFFFF;
    stepCycle();
    WE = 1'b0; RE = 1'b1;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h1234FFFF) $display("FAIL full_mask_nowrite: got %h want %h", RDATA, 32'h1234FFFF);
    else passCnt++;
  endtask

  task automatic test_enables();
    idleInputs();
    WE = 1'b1; WCLKE = 1'b0; WADDR = 8'd3; WDATA = 32'h0; MASK = 32'h0;
    stepCycle();
    WE = 1'b0; RE = 1'b1; RCLKE = 1'b1; RADDR = 8'd3;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h1234FFFF) $display("FAIL wclke_gate: got %h want %h", RDATA, 32'h1234FFFF);
    else passCnt++;
    RCLKE = 1'b0; RADDR = 8'd5;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h1234FFFF) $display("FAIL rclke_hold: got %h want %h", RDATA, 32'h1234FFFF);
    else passCnt++;
    RCLKE = 1'b1; RE = 1'b0; RADDR = 8'd0;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h1234FFFF) $display("FAIL re_hold: got %h want %h", RDATA, 32'h1234FFFF);
    else passCnt++;
  endtask

  task automatic test_collision();
    logic [31:0] want;
    idleInputs();
    preload(7, 32'hAAAAAAAA);
    WE = 1'b1; WCLKE = 1'b1; WADDR = 8'd7; WDATA = 32'h55555555; MASK = 32'h0;
    RE = 1'b1; RCLKE = 1'b1; RADDR = 8'd7;
    stepCycle();
`ifdef ICE_RAM32_BYPASS_EN
    want = 32'h55555555;
`else
    want = 32'hAAAAAAAA;
`endif
    checkCnt++;
    if (RDATA !== want) $display("FAIL collision: got %h want %h", RDATA, want);
    else passCnt++;
    WE = 1'b0;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h55555555) $display("FAIL collision_after: got %h want %h", RDATA, 32'h55555555);
    else passCnt++;
  endtask

  task automatic test_independence();
    logic [31:0] want;
    idleInputs();
    preload(31, 32'h00000001);
    preload(30, 32'h0BADF00D);
    WE = 1'b1; WCLKE = 1'b1; WADDR = 8'd31; WDATA = 32'h11111111; MASK = 32'h0;
    RE = 1'b1; RCLKE = 1'b1; RADDR = 8'd31;
    stepCycle();
`ifdef ICE_RAM32_BYPASS_EN
    want = 32'h11111111;
`else
    want = 32'h00000001;
`endif
    checkCnt++;
    if (RDATA !== want) $display("FAIL indep_collide: got %h want %h", RDATA, want);
    else passCnt++;
    WADDR = 8'd30; WDATA = 32'h77777777;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h11111111) $display("FAIL indep_other_addr: got %h want %h", RDATA, 32'h11111111);
    else passCnt++;
    WE = 1'b0; RADDR = 8'd30;
    stepCycle();
    checkCnt++;
    if (RDATA !== 32'h77777777) $display("FAIL indep_read30: got %h want %h", RDATA, 32'h77777777);
    else passCnt++;
  endtask

  task automatic test_random();
    logic [31:0] want;
    for (int i = 0; i < 400; i++) begin
      RE    = ($urandom_range(0, 3) != 0);
      RCLKE = ($urandom_range(0, 3) != 0);
      WE    = ($urandom_range(0, 1) != 0);
      WCLKE = ($urandom_range(0, 3) != 0);
      RADDR = 8'($urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 31));
      WADDR = ($urandom_range(0, 3) == 0) ? RADDR : 8'($urandom_range(0, 31));
      WDATA = $urandom;
      case ($urandom_range(0, 3))
        0:       MASK = 32'h0;
        1:       MASK = 32'hFFFFFFFF;
        default: MASK = $urandom;
      endcase
      grst  = ($urandom_range(0, 49) != 0);
      stepCycle();
      exp_q.push_back(expRd);
      want = exp_q.pop_front();
      checkCnt++;
      if (RDATA !== want) $display("FAIL random cyc %0d: got %h want %h", i, RDATA, want);
      else passCnt++;
    end
    grst = 1'b1;
    // Sweep words 0..31 to compare the full register-file region.
    idleInputs();
    RE = 1'b1; RCLKE = 1'b1;
    for (int a = 0; a < 32; a++) begin
      RADDR = 8'(a);
      stepCycle();
      checkCnt++;
      if (RDATA !== model[a]) $display("FAIL sweep addr %0d: got %h want %h", a, RDATA, model[a]);
      else passCnt++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idleInputs();
    grst = 1'b0;
    expRd = 32'h0;
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    #1;
    test_reset();
    test_masked_write();
    test_enables();
    test_collision();
    test_independence();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/ice_ram32.md
Name: ice_ram32

Overview:
- 256 x 32 synchronous simple-dual-port RAM.
- Has one write port and one registered read port, with a per-bit write mask, modelled on the iCE40 block-RAM primitive interface.
- Used as the storage behind the CPU register file; three copies share one write port and have independent read addresses.
- The instantiator supplies the clock phase it needs, e.g. an inverted core clock.

Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W words.
- DATA_W, 32, word width for data, mask and read data.

Ports:
- gclk  in  1  clock; all storage and read registers update on its rising edge.
- grst  in  1  asynchronous active-low reset.
- RDATA  out  32  registered read data.
- RADDR  in  8  read address.
- RE  in  1  read enable.
- RCLKE  in  1  read clock enable.
- WDATA  in  32  write data.
- MASK  in  32  per-bit write mask; 1 = bit not written.
- WADDR  in  8  write address.
- WE  in  1  write enable.
- WCLKE  in  1  write clock enable.

Behaviour:
- Storage: array of 2^ADDR_W words of DATA_W bits.
  - Not cleared by reset.
  - Power-up contents are undefined; the simulation bench preloads them through the backdoor.
- Write: on a rising gclk edge with WE=1 and WCLKE=1, every bit i where MASK[i]=0 becomes WDATA[i]. Bits where MASK[i]=1 keep their old value.
  - MASK=0 is a full-word write. MASK=all-ones writes nothing.
- Writes are NOT gated by grst. The register file relies on writing R0=0 while reset is held, so writes proceed normally during reset.
- Read: on a rising gclk edge with RE=1 and RCLKE=1 and grst=1, RDATA <= mem[RADDR]. Latency is 1 cycle.
  - When RE=0 or RCLKE=0, RDATA holds its previous value.
- Reset: grst=0 asynchronously forces RDATA to 0 and holds it at 0 while asserted.
  - The first read captured after release occurs at the first rising edge with grst=1.
- Read-during-write to the same address in the same edge is read-first: RDATA gets the pre-write word (unless the bypass feature is enabled).
- Different addresses are fully independent. Simultaneous read and write each complete in the same edge.
- Addresses are exactly ADDR_W bits wide, so there is no out-of-range case. The upper 3 address bits are tied 0 by the register file, which uses words 0..31 only.
- No X propagation is introduced by the block itself. Unwritten words read as their preloaded or power-up value.

Optional Feature:
- Macro ICE_RAM32_BYPASS_EN.
- Defined: on a same-address read/write collision (RADDR==WADDR, read enabled, write enabled), RDATA takes the merged new word: (WDATA & ~MASK) | (old & MASK). This is write-first behaviour.
- Undefined: read-first, as specified above.
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package ice_ram_pkg holds:
  - ICE_RAM_ADDR_W=8 and ICE_RAM_DATA_W=32 constants;
  - typedefs ice_ram_addr_t and ice_ram_word_t.
- One sub-module, ice_ram32_array, is the storage plus masked write logic.
  - It must be instantiated with instance name "ram", and its array must be named "r_data".
  - The bench and register file preload words through the hierarchical path <inst>.ram.r_data[i].
- The read register and reset logic live in the top module.

Test Plan:
- Reset: hold grst=0 with RE=1, RCLKE=1 and RADDR=5 pointing at a nonzero word -> RDATA=0 throughout. After release, the first edge gives RDATA=mem[5].
- Write during reset: grst=0, WE=1, WCLKE=1, WADDR=0, WDATA=0, MASK=0 over preloaded 0xDEADBEEF -> after release, reading address 0 gives 0x00000000.
- Masked write: mem[3]=0x12345678; write WDATA=0xFFFFFFFF, MASK=0xFFFF0000 -> read gives 0x1234FFFF one cycle after the read edge.
- Enables: WE=1 with WCLKE=0 leaves mem unchanged. RE=1 with RCLKE=0 (or RE=0) while RADDR changes -> RDATA holds its last value.
- Collision: mem[7]=0xAAAAAAAA; same edge write 0x55555555 (MASK=0) and read address 7 -> RDATA=0xAAAAAAAA by default, or 0x55555555 with ICE_RAM32_BYPASS_EN. The next read gives 0x55555555 in both builds.
- Independence: write 0x11111111 to address 31 while reading address 31 preloaded with 1 -> RDATA=0x00000001 in the default build. A later write to address 30 leaves address 31 unchanged.
